prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/sap_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 37 +++
 rtl/loader_ctr.sv | 39 +++
 rtl/prog_loader.sv | 104 ++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP program loader.
// Holds the loader FSM encoding, RAM geometry and the length-saturation helper.
package sap_pkg;

   localparam int RAM_AW  = 4;
   localparam int RAM_DW  = 8;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Requests longer than the RAM are clipped to one full RAM image.
   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host, CPU and RAM-side signals of the program loader bundled in one interface.
// Byte handshake: a byte moves on a rising edge where in_valid and in_ready are both high.
interface prog_loader_if;
   import sap_pkg::*;

   logic                start;
   logic [RAM_AW-1:0]   base;
   logic [LEN_W-1:0]    len;
   logic                in_valid;
   logic [RAM_DW-1:0]   in_data;
   logic                in_ready;
   logic                cpu_req;
   logic [RAM_AW-1:0]   cpu_addr;
   logic                cpu_gnt;
   logic [RAM_AW-1:0]   ram_addr;
   logic [RAM_DW-1:0]   ram_wdata;
   logic                ram_we;
   logic                cpu_hold;
   logic                busy;
   logic                done;
   logic [RAM_DW-1:0]   csum;
   logic                err;
   state_t              dbg_state;

   modport master (
      output start, base, len, in_valid, in_data, cpu_req, cpu_addr,
      input  in_ready, cpu_gnt, ram_addr, ram_wdata, ram_we, cpu_hold,
             busy, done, csum, err, dbg_state
   );

   modport slave (
      input  start, base, len, in_valid, in_data, cpu_req, cpu_addr,
      output in_ready, cpu_gnt, ram_addr, ram_wdata, ram_we, cpu_hold,
             busy, done, csum, err, dbg_state
   );

endinterface

// File: rtl/loader_ctr.sv
// RAM write-address and remaining-byte counter for the program loader.
// Load takes priority over step; the address wraps at the top of RAM.
module loader_ctr
   import sap_pkg::*;
(
   input  logic              CLK,
   input  logic              CLR,
   input  logic              i_load,
   input  logic [RAM_AW-1:0] i_base,
   input  logic [LEN_W-1:0]  i_len,
   input  logic              i_step,
   output logic [RAM_AW-1:0] o_addr,
   output logic [LEN_W-1:0]  o_remaining,
   output logic              o_last,
   output logic              o_zero
);

   logic [RAM_AW-1:0] r_addr;
   logic [LEN_W-1:0]  r_remaining;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_addr      <= '0;
         r_remaining <= '0;
      end else if (i_load) begin
         r_addr      <= i_base;
         r_remaining <= i_len;
      end else if (i_step) begin
         r_addr      <= r_addr + RAM_AW'(1);
         r_remaining <= r_remaining - LEN_W'(1);
      end
   end

   assign o_addr      = r_addr;
   assign o_remaining = r_remaining;
   assign o_last      = (r_remaining == LEN_W'(1));
   assign o_zero      = (r_remaining == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams host bytes into the SAP RAM while holding the CPU off,
// and hands the RAM port back to the CPU when idle.
module prog_loader
   import sap_pkg::*;
(
   input  logic         CLK,
   input  logic         CLR,
   prog_loader_if.slave bus
);

   state_t            r_state;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [RAM_DW-1:0] r_csum;

   logic              w_accept;
   logic              w_xfer;
   logic [RAM_AW-1:0] w_addr;
   logic [LEN_W-1:0]  w_remaining;
   logic              w_last;
   logic              w_zero;

   assign w_accept = (r_state == S_IDLE) && bus.start;
   assign w_xfer   = r_in_ready && bus.in_valid;

   loader_ctr u_ctr (
      .CLK         (CLK),
      .CLR         (CLR),
      .i_load      (w_accept),
      .i_base      (bus.base),
      .i_len       (sat_len(bus.len)),
      .i_step      (w_xfer),
      .o_addr      (w_addr),
      .o_remaining (w_remaining),
      .o_last      (w_last),
      .o_zero      (w_zero)
   );

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_csum     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_err  <= 1'b0;
                  r_csum <= '0;
                  r_busy <= 1'b1;
                  // A zero-length request still produces a done pulse.
                  if (bus.len != '0) begin
                     r_state    <= S_LOAD;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bus.start) r_err <= 1'b1;
               if (w_xfer) begin
                  r_csum <= r_csum + bus.in_data;
                  if (w_last) begin
                     r_state    <= S_DONE;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (bus.start) r_err <= 1'b1;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.ram_we    = w_xfer;
   assign bus.ram_addr  = (r_state == S_IDLE) ? bus.cpu_addr : w_addr;
   assign bus.ram_wdata = (r_state == S_LOAD) ? bus.in_data : '0;
   assign bus.cpu_gnt   = (r_state == S_IDLE) && bus.cpu_req;
   assign bus.cpu_hold  = r_busy;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.csum      = r_csum;
   assign bus.err       = r_err;
   assign bus.dbg_state = r_state;

endmodule
